// File: rtl/hazard_scoreboard_unit.sv
// Hazard controller: shadow pipe of destination tags after ID, driving EX forwarding selects,
// load-use stalls, branch flushes and multi-cycle EX freezes, with saturating event counters.
module hazard_scoreboard_unit #(
  parameter int NUM_REGS   = 32,
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16,
  parameter int RW         = $clog2(NUM_REGS),
  parameter int FW         = $clog2(PIPE_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_i,
  input  logic [RW-1:0]    id_rs1_i,
  input  logic [RW-1:0]    id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [RW-1:0]    id_rd_i,
  input  logic             id_reg_write_i,
  input  logic             id_mem_read_i,
  input  logic             ex_branch_tkn_i,
  input  logic             ex_stall_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic [FW-1:0]    fwd_a_o,
  output logic [FW-1:0]    fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef struct packed {
    logic          v;
    logic [RW-1:0] rd;
    logic          rw;
    logic          ld;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic          u1;
    logic          u2;
  } entry_t;

  entry_t           e_q [PIPE_DEPTH];
  entry_t           e_d [PIPE_DEPTH];
  entry_t           id_entry_s;
  logic             flush_s;
  logic             luse_s;
  logic             stall_s;
  logic [FW-1:0]    fwd_a_s;
  logic [FW-1:0]    fwd_b_s;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Load results only become forwardable once they reach LOAD_STAGE.
  function automatic logic fwd_hit(input entry_t src, input int k, input logic [RW-1:0] rs);
    return src.v && src.rw && (src.rd != '0) && (src.rd == rs) && (!src.ld || (k >= LOAD_STAGE));
  endfunction

  always_comb begin
    id_entry_s = {id_valid_i, id_rd_i, id_reg_write_i, id_mem_read_i,
                  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i};
    luse_s = 1'b0;
    for (int s = 0; s < PIPE_DEPTH; s++) begin
      luse_s = luse_s | ((s < LOAD_STAGE - 1) && e_q[s].v && e_q[s].ld && e_q[s].rw &&
                         (e_q[s].rd != '0) &&
                         ((id_use_rs1_i && (e_q[s].rd == id_rs1_i)) ||
                          (id_use_rs2_i && (e_q[s].rd == id_rs2_i))));
    end
    luse_s  = luse_s & id_valid_i;
    flush_s = ex_branch_tkn_i & ~ex_stall_i;
    stall_s = ~flush_s & (ex_stall_i | luse_s);
  end

  always_comb begin
    e_d[0] = '0;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      e_d[k] = e_q[k-1];
    end
    if (flush_s) begin
      e_d[0] = '0;
    end else if (ex_stall_i) begin
      e_d[0] = e_q[0];
      e_d[1] = '0;
    end else if (luse_s) begin
      e_d[0] = '0;
    end else begin
      e_d[0] = id_entry_s;
    end
    stall_cnt_d = (stall_s && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush_s && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  // Scan from the oldest stage down so the youngest matching producer wins.
  always_comb begin
    fwd_a_s = '0;
    fwd_b_s = '0;
    for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
      fwd_a_s = (e_q[0].u1 && fwd_hit(e_q[k], k, e_q[0].rs1)) ? FW'(k) : fwd_a_s;
      fwd_b_s = (e_q[0].u2 && fwd_hit(e_q[k], k, e_q[0].rs2)) ? FW'(k) : fwd_b_s;
    end
  end

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    fwd_a_o       = e_q[0].v ? fwd_a_s : '0;
    fwd_b_o       = e_q[0].v ? fwd_b_s : '0;
    if (rst) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
      fwd_a_o       = '0;
      fwd_b_o       = '0;
    end else if (flush_s) begin
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (ex_stall_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
    end else if (luse_s) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        e_q[k] <= '0;
      end
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: an instruction-level pipe model checks every cycle,
// plus hand-computed expectations for the documented scenarios. A CNT_W=2 copy exercises saturation.
module tb_hazard_scoreboard_unit;

  localparam int DEPTH = 3;
  localparam int LS    = 2;
  localparam int W1    = 16;
  localparam int W2    = 2;

  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit ld;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
  } ins_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid_i = 1'b0, id_use_rs1_i = 1'b0, id_use_rs2_i = 1'b0;
  logic id_reg_write_i = 1'b0, id_mem_read_i = 1'b0, ex_branch_tkn_i = 1'b0, ex_stall_i = 1'b0;
  logic [4:0] id_rs1_i = 5'd0, id_rs2_i = 5'd0, id_rd_i = 5'd0;

  logic pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o;
  logic [1:0] fwd_a_o, fwd_b_o;
  logic [W1-1:0] stall_cnt_o, flush_cnt_o;
  logic s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble;
  logic [1:0] s_fwd_a, s_fwd_b;
  logic [W2-1:0] s_stall_cnt, s_flush_cnt;

  int nchk = 0;
  int nerr = 0;
  ins_t pipe [DEPTH];
  int scnt = 0;
  int fcnt = 0;

  hazard_scoreboard_unit #(.CNT_W(W1)) u_dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i), .id_rd_i(id_rd_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
    .ex_branch_tkn_i(ex_branch_tkn_i), .ex_stall_i(ex_stall_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
    .idex_bubble_o(idex_bubble_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  hazard_scoreboard_unit #(.CNT_W(W2)) u_sat (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i), .id_rd_i(id_rd_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
    .ex_branch_tkn_i(ex_branch_tkn_i), .ex_stall_i(ex_stall_i),
    .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write), .ifid_flush_o(s_ifid_flush),
    .idex_bubble_o(s_idex_bubble), .fwd_a_o(s_fwd_a), .fwd_b_o(s_fwd_b),
    .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk = nchk + 1;
    if (act !== exp) begin
      nerr = nerr + 1;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic ins_t id_ins();
    ins_t t;
    t.v = id_valid_i;  t.rd = int'(id_rd_i);   t.rw = id_reg_write_i; t.ld = id_mem_read_i;
    t.rs1 = int'(id_rs1_i); t.rs2 = int'(id_rs2_i); t.u1 = id_use_rs1_i; t.u2 = id_use_rs2_i;
    return t;
  endfunction

  // A load still in a stage before LS cannot supply a value the ID instruction needs.
  function automatic bit model_luse();
    bit hit = 1'b0;
    for (int s = 0; s < LS - 1; s++) begin
      if (pipe[s].v && pipe[s].ld && pipe[s].rw && pipe[s].rd != 0 &&
          ((id_use_rs1_i && pipe[s].rd == int'(id_rs1_i)) ||
           (id_use_rs2_i && pipe[s].rd == int'(id_rs2_i))))
        hit = 1'b1;
    end
    return id_valid_i && hit;
  endfunction

  function automatic int model_fwd(input int rs, input bit use_it);
    if (!pipe[0].v || !use_it) return 0;
    for (int k = 1; k < DEPTH; k++) begin
      if (pipe[k].v && pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == rs && (!pipe[k].ld || k >= LS))
        return k;
    end
    return 0;
  endfunction

  // Returns {pc_write, ifid_write, ifid_flush, idex_bubble}.
  function automatic logic [3:0] exp_ctl();
    if (rst) return 4'b0011;
    if (ex_branch_tkn_i && !ex_stall_i) return 4'b1111;
    if (ex_stall_i) return 4'b0000;
    if (model_luse()) return 4'b0001;
    return 4'b1100;
  endfunction

  function automatic logic exp_bit(input int i);
    logic [3:0] c = exp_ctl();
    return c[i];
  endfunction

  function automatic int sat(input int c, input int w);
    int m = (1 << w) - 1;
    return (c > m) ? m : c;
  endfunction

  function automatic int exp_fa();
    return rst ? 0 : model_fwd(pipe[0].rs1, pipe[0].u1);
  endfunction

  function automatic int exp_fb();
    return rst ? 0 : model_fwd(pipe[0].rs2, pipe[0].u2);
  endfunction

  always @(posedge clk or posedge rst) begin : model
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) pipe[k] <= '{default: 0};
      scnt <= 0;
      fcnt <= 0;
    end else if (ex_branch_tkn_i && !ex_stall_i) begin
      pipe[2] <= pipe[1]; pipe[1] <= pipe[0]; pipe[0] <= '{default: 0};
      fcnt <= fcnt + 1;
    end else if (ex_stall_i) begin
      pipe[2] <= pipe[1]; pipe[1] <= '{default: 0};
      scnt <= scnt + 1;
    end else if (model_luse()) begin
      pipe[2] <= pipe[1]; pipe[1] <= pipe[0]; pipe[0] <= '{default: 0};
      scnt <= scnt + 1;
    end else begin
      pipe[2] <= pipe[1]; pipe[1] <= pipe[0]; pipe[0] <= id_ins();
    end
  end

  always @(negedge clk) begin : compare
    chk("pc_write",    32'(pc_write_o),    32'(exp_bit(3)));
    chk("ifid_write",  32'(ifid_write_o),  32'(exp_bit(2)));
    chk("ifid_flush",  32'(ifid_flush_o),  32'(exp_bit(1)));
    chk("idex_bubble", 32'(idex_bubble_o), 32'(exp_bit(0)));
    chk("fwd_a",       32'(fwd_a_o),       32'(exp_fa()));
    chk("fwd_b",       32'(fwd_b_o),       32'(exp_fb()));
    chk("stall_cnt",   32'(stall_cnt_o),   32'(rst ? 0 : sat(scnt, W1)));
    chk("flush_cnt",   32'(flush_cnt_o),   32'(rst ? 0 : sat(fcnt, W1)));
    chk("sat_pc_write",  32'(s_pc_write),  32'(exp_bit(3)));
    chk("sat_fwd_a",     32'(s_fwd_a),     32'(exp_fa()));
    chk("sat_stall_cnt", 32'(s_stall_cnt), 32'(rst ? 0 : sat(scnt, W2)));
    chk("sat_flush_cnt", 32'(s_flush_cnt), 32'(rst ? 0 : sat(fcnt, W2)));
  end

  task automatic put(input bit v, input int rd, input int rs1, input int rs2, input bit rw,
                     input bit ld, input bit u1, input bit u2, input bit br, input bit st);
    id_valid_i = v;       id_rd_i = 5'(rd);       id_rs1_i = 5'(rs1);   id_rs2_i = 5'(rs2);
    id_reg_write_i = rw;  id_mem_read_i = ld;     id_use_rs1_i = u1;    id_use_rs2_i = u2;
    ex_branch_tkn_i = br; ex_stall_i = st;
    #2;
  endtask

  task automatic alu(input int rd, input int rs1, input int rs2, input bit br = 1'b0);
    put(1'b1, rd, rs1, rs2, 1'b1, 1'b0, 1'b1, 1'b1, br, 1'b0);
  endtask

  task automatic ldi(input int rd, input int rs1);
    put(1'b1, rd, rs1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nop(input bit st = 1'b0);
    put(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, st);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nop();
    chk("rst_pc_write", 32'(pc_write_o), 32'd0);
    chk("rst_ifid_flush", 32'(ifid_flush_o), 32'd1);
    chk("rst_idex_bubble", 32'(idex_bubble_o), 32'd1);
    chk("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
    @(posedge clk);
    tick();
    rst = 1'b0;

    // add x5; add x6,x5
    alu(5, 1, 2);   tick();
    alu(6, 5, 3);   chk("t1_pc_write", 32'(pc_write_o), 32'd1); tick();
    nop();          chk("t1_fwd_a", 32'(fwd_a_o), 32'd1); chk("t1_fwd_b", 32'(fwd_b_o), 32'd0);
                    chk("t1_stall_cnt", 32'(stall_cnt_o), 32'd0); tick();
    // add x5; nop; sub x7,x0,x5
    alu(5, 1, 2);   tick();
    nop();          tick();
    alu(7, 0, 5);   tick();
    nop();          chk("t2_fwd_b", 32'(fwd_b_o), 32'd2); chk("t2_fwd_a", 32'(fwd_a_o), 32'd0); tick();
    // ld x5; add x6,x5
    ldi(5, 1);      tick();
    alu(6, 5, 4);   chk("t3_pc_write", 32'(pc_write_o), 32'd0);
                    chk("t3_idex_bubble", 32'(idex_bubble_o), 32'd1); tick();
    alu(6, 5, 4);   chk("t3_resume", 32'(pc_write_o), 32'd1); tick();
    nop();          chk("t3_fwd_a", 32'(fwd_a_o), 32'd2); chk("t3_stall_cnt", 32'(stall_cnt_o), 32'd1); tick();
    // branch taken while a load-use stall is pending
    ldi(5, 1);      tick();
    alu(6, 5, 4, 1'b1);
                    chk("t4_ifid_flush", 32'(ifid_flush_o), 32'd1); chk("t4_pc_write", 32'(pc_write_o), 32'd1);
                    tick();
    nop();          chk("t4_flush_cnt", 32'(flush_cnt_o), 32'd1); chk("t4_stall_cnt", 32'(stall_cnt_o), 32'd1); tick();
    // ex_stall for 3 cycles under a dependent add
    alu(8, 1, 2);   tick();
    alu(9, 8, 8);   tick();
    nop(1'b1);      chk("t5_pc_write", 32'(pc_write_o), 32'd0); chk("t5_fwd_a0", 32'(fwd_a_o), 32'd1); tick();
    nop(1'b1);      chk("t5_fwd_a1", 32'(fwd_a_o), 32'd2); tick();
    nop(1'b1);      chk("t5_fwd_a2", 32'(fwd_a_o), 32'd0); tick();
    alu(10, 9, 1);  chk("t5_stall_cnt", 32'(stall_cnt_o), 32'd4); chk("t5_sat_cnt", 32'(s_stall_cnt), 32'd3); tick();
    nop();          chk("t5_fwd_resume", 32'(fwd_a_o), 32'd1); tick();
    // x0 never forwards and never stalls
    alu(0, 1, 2);   tick();
    alu(11, 0, 0);  tick();
    nop();          chk("t6_fwd_a_x0", 32'(fwd_a_o), 32'd0); chk("t6_fwd_b_x0", 32'(fwd_b_o), 32'd0); tick();
    ldi(0, 1);      tick();
    alu(12, 0, 0);  chk("t6_ld_x0_nostall", 32'(pc_write_o), 32'd1); tick();
    nop();          tick();
    // reset in the middle of an ex_stall
    nop(1'b1);      tick();
    nop(1'b1);      chk("t6_stall_cnt5", 32'(stall_cnt_o), 32'd5); chk("t6_sat_cnt5", 32'(s_stall_cnt), 32'd3);
    rst = 1'b1;
    #1;
    chk("t6_rst_pc_write", 32'(pc_write_o), 32'd0);
    chk("t6_rst_ifid_flush", 32'(ifid_flush_o), 32'd1);
    chk("t6_rst_fwd_a", 32'(fwd_a_o), 32'd0);
    chk("t6_rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
    chk("t6_rst_flush_cnt", 32'(flush_cnt_o), 32'd0);
    tick();
    rst = 1'b0;
    alu(5, 1, 2);   chk("t6_post_rst_pc", 32'(pc_write_o), 32'd1); tick();
    alu(6, 5, 5);   tick();
    nop();          chk("t6_post_fwd_a", 32'(fwd_a_o), 32'd1); chk("t6_post_fwd_b", 32'(fwd_b_o), 32'd1); tick();
    nop();          tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
